// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the ALU decoder and the sequential execute stage.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'h0,
    SUB  = 4'h1,
    AND  = 4'h2,
    OR   = 4'h3,
    XOR  = 4'h4,
    SLT  = 4'h5,
    SLTU = 4'h6,
    SLL  = 4'h7,
    SRA  = 4'h8,
    SRL  = 4'h9
  } aluop_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == SLL) || (code == SRA) || (code == SRL);
  endfunction

  function automatic logic is_illegal(input logic [3:0] code);
    return code > 4'h9;
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle arithmetic/logic/compare datapath plus illegal-code detection.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       aluControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (aluControl)
      ADD:  result = srcA + srcB;
      SUB:  result = srcA - srcB;
      AND:  result = srcA & srcB;
      OR:   result = srcA | srcB;
      XOR:  result = srcA ^ srcB;
      SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      SLTU: result = {{(WIDTH-1){1'b0}}, (srcA < srcB)};
      default: illegal = is_illegal(aluControl);
    endcase
  end

endmodule

// File: rtl/seq_alu_unit.sv
// ALU execute stage: one-cycle arith/logic ops, bit-serial shifts, valid/ready on both sides.
module seq_alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [3:0]       aluControl,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] aluResult,
  output logic             zero,
  output logic             illegalOp
);

  alu_state_e         state;
  aluop_e             shop;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] count;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   core_result;
  logic               core_illegal;
  logic [WIDTH-1:0]   first_step;
  logic [WIDTH-1:0]   next_step;

  function automatic logic [WIDTH-1:0] shift1(input aluop_e op, input logic [WIDTH-1:0] v);
    case (op)
      SLL:     return {v[WIDTH-2:0], 1'b0};
      SRA:     return {v[WIDTH-1], v[WIDTH-1:1]};
      default: return {1'b0, v[WIDTH-1:1]};
    endcase
  endfunction

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .aluControl (aluControl),
    .srcA       (srcA),
    .srcB       (srcB),
    .result     (core_result),
    .illegal    (core_illegal)
  );

  assign shamt      = srcB[SHAMT_W-1:0];
  assign first_step = shift1(aluop_e'(aluControl), srcA);
  assign next_step  = shift1(shop, work);
  assign inReady    = (state == IDLE);
  assign outValid   = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shop      <= SLL;
      work      <= '0;
      count     <= '0;
      aluResult <= '0;
      zero      <= 1'b0;
      illegalOp <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            if (is_shift(aluControl)) begin
              shop <= aluop_e'(aluControl);
              // The accept edge already performs the first bit of the shift so
              // that accept-to-outValid latency equals the shift amount.
              if (shamt == '0) begin
                aluResult <= srcA;
                zero      <= (srcA == '0);
                illegalOp <= 1'b0;
                state     <= DONE;
              end else if (shamt == SHAMT_W'(1)) begin
                aluResult <= first_step;
                zero      <= (first_step == '0);
                illegalOp <= 1'b0;
                state     <= DONE;
              end else begin
                work  <= first_step;
                count <= shamt - 1'b1;
                state <= SHIFT;
              end
            end else begin
              aluResult <= core_result;
              zero      <= (core_result == '0);
              illegalOp <= core_illegal;
              state     <= DONE;
            end
          end
        end
        SHIFT: begin
          work  <= next_step;
          count <= count - 1'b1;
          if (count == SHAMT_W'(1)) begin
            aluResult <= next_step;
            zero      <= (next_step == '0);
            illegalOp <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (outReady) begin
            zero      <= 1'b0;
            illegalOp <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Scoreboard bench for seq_alu_unit: directed vectors, queued expectations, decoupled monitor.
module tb_seq_alu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [3:0]  aluControl;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        outValid;
  logic        outReady;
  logic [31:0] aluResult;
  logic        zero;
  logic        illegalOp;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  seq_alu_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .inValid    (inValid),
    .inReady    (inReady),
    .aluControl (aluControl),
    .srcA       (srcA),
    .srcB       (srcB),
    .outValid   (outValid),
    .outReady   (outReady),
    .aluResult  (aluResult),
    .zero       (zero),
    .illegalOp  (illegalOp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller is positioned at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic z, input logic ill, input int lat);
    exp_t e;
    aluControl = op;
    srcA       = a;
    srcB       = b;
    inValid    = 1'b1;
    for (int i = 0; i < 200 && !inReady; i++) @(negedge clk);
    if (!inReady) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.res = r;
      e.z   = z;
      e.ill = ill;
      e.cyc = cyc + lat;
      sbq.push_back(e);
    end
    @(negedge clk);
    inValid    = 1'b0;
    srcA       = $urandom;
    srcB       = $urandom;
    aluControl = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("drain_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  // Monitor: samples just after the falling edge, once the stimulus drives have settled.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (outValid) begin
          if (sbq.size() == 0) begin
            chk("spurious_outvalid", 32'd1, 32'd0);
          end else begin
            e = sbq[0];
            if (!prev) chk("latency_cycle", 32'(cyc), 32'(e.cyc));
            chk("aluResult", aluResult, e.res);
            chk("zero", 32'(zero), 32'(e.z));
            chk("illegalOp", 32'(illegalOp), 32'(e.ill));
            chk("inReady_in_done", 32'(inReady), 32'd0);
            if (outReady) void'(sbq.pop_front());
          end
        end
        prev = outValid;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset      = 1'b1;
    inValid    = 1'b0;
    outReady   = 1'b1;
    aluControl = 4'h0;
    srcA       = '0;
    srcB       = '0;
    repeat (3) @(negedge clk);
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_inReady", 32'(inReady), 32'd1);
    chk("rst_aluResult", aluResult, 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_illegalOp", 32'(illegalOp), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // One-cycle operations
    issue(4'h0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1); drain();
    issue(4'h1, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0, 1); drain();
    issue(4'h1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1); drain();
    issue(4'h5, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1); drain();
    issue(4'h6, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1); drain();
    issue(4'h5, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1); drain();
    issue(4'h6, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1); drain();
    issue(4'h2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1); drain();
    issue(4'h3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 1); drain();
    issue(4'h4, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1'b0, 1); drain();

    // Shifts: latency equals shift amount, minimum one cycle
    issue(4'h8, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1'b0, 4); drain();
    issue(4'h9, 32'h8000_0010, 32'd4, 32'h0800_0001, 1'b0, 1'b0, 4); drain();
    issue(4'h7, 32'h1, 32'hFFFF_FFE0, 32'h1, 1'b0, 1'b0, 1); drain();
    issue(4'h7, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 31); drain();
    issue(4'h9, 32'h8000_0000, 32'd1, 32'h4000_0000, 1'b0, 1'b0, 1); drain();
    issue(4'h9, 32'h8000_0000, 32'hFFFF_FF3F, 32'h1, 1'b0, 1'b0, 31); drain();

    // Illegal codes, then flags must be cleared back in IDLE
    issue(4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b1, 1); drain();
    issue(4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1); drain();
    chk("idle_illegalOp_clear", 32'(illegalOp), 32'd0);
    chk("idle_zero_clear", 32'(zero), 32'd0);
    chk("idle_outValid", 32'(outValid), 32'd0);

    // Backpressure: result held while a new request waits
    outReady = 1'b0;
    issue(4'h0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);
    aluControl = 4'h4;
    srcA       = 32'd3;
    srcB       = 32'd3;
    inValid    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_inReady", 32'(inReady), 32'd0);
      chk("stall_outValid", 32'(outValid), 32'd1);
      @(negedge clk);
    end
    outReady = 1'b1;
    issue(4'h4, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1); drain();

    // Reset aborts an in-flight shift
    issue(4'h7, 32'h1, 32'd20, 32'h0010_0000, 1'b0, 1'b0, 20);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sbq.delete();
    chk("abort_outValid", 32'(outValid), 32'd0);
    chk("abort_inReady", 32'(inReady), 32'd1);
    chk("abort_aluResult", aluResult, 32'd0);
    issue(4'h7, 32'h3, 32'd20, 32'h0030_0000, 1'b0, 1'b0, 20); drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu_unit.md
Name: seq_alu_unit

Overview:
Multi-cycle ALU execute stage directly downstream of the ALU decoder; consumes its 4-bit aluControl plus two operands and produces a registered result and zero flag. Arithmetic and logic ops complete in one cycle. Shifts run iteratively, one bit per cycle, to save area. Input and output use valid/ready handshakes so a stalling datapath can sit on either side.

Parameters:
WIDTH, 32, operand/result width; must be a power of 2, >= 8
SHAMT_W, $clog2(WIDTH), shift-amount bits taken from srcB[SHAMT_W-1:0]

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
inValid  in  1  operation request valid
inReady  out  1  unit can accept a request (high only in IDLE)
aluControl  in  4  op code: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 sra, 9 srl; 10-15 illegal
srcA  in  WIDTH  operand A (shift source)
srcB  in  WIDTH  operand B (shift amount in low SHAMT_W bits)
outValid  out  1  result valid
outReady  in  1  consumer accepts result
aluResult  out  WIDTH  registered result
zero  out  1  aluResult == 0, registered with result
illegalOp  out  1  result belongs to an illegal aluControl code

Behaviour:
- Reset (sync, active-high): state=IDLE; aluResult=0, zero=0, illegalOp=0, outValid=0, shift counter=0. Reset mid-shift or mid-DONE aborts; the pending result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE: inReady=1, outValid=0. Accept on inValid&inReady.
  - codes 0-6: compute combinationally, register aluResult/zero; next DONE. Latency 1 cycle (outValid the cycle after accept).
  - codes 7-9: load working reg=srcA, count=srcB[SHAMT_W-1:0], latch op. If count==0: result=srcA, next DONE (1 cycle). Else next SHIFT.
  - codes 10-15: aluResult=0, zero=1, illegalOp=1; next DONE.
- SHIFT: inReady=0. Each cycle shift working reg by 1 (sll: zero fill LSB; srl: zero fill MSB; sra: replicate MSB) and decrement count. When count reaches 0, write the result to aluResult/zero and go to DONE. Total accept-to-outValid latency = max(1, shamt) cycles.
- DONE: outValid=1, inReady=0; outputs held stable until outReady. On outReady: next IDLE, outValid drops next cycle. No new accept in DONE: max throughput is 1 op per 2 cycles.
- Arithmetic: add/sub modulo 2^WIDTH, carry discarded. slt is a signed compare, sltu is unsigned; result 1 or 0, zero-extended. Shift amount uses only the low SHAMT_W bits of srcB; upper bits are ignored.
- Inputs are sampled only at accept; later changes to srcA/srcB/aluControl have no effect.
- illegalOp and zero are valid only while outValid=1; they are cleared on return to IDLE.
- inValid held high while inReady=0 is legal: the request is taken on the first IDLE cycle.

Decomposition:
- Package alu_pkg: enum aluop_e (ADD=4'h0, SUB=4'h1, AND=4'h2, OR=4'h3, XOR=4'h4, SLT=4'h5, SLTU=4'h6, SLL=4'h7, SRA=4'h8, SRL=4'h9); state enum alu_state_e {IDLE, SHIFT, DONE}. The decoder and this unit share the package.
- One sub-module, alu_comb_core: purely combinational codes 0-6 plus the illegal-op flag. The FSM, shift register and counter stay in seq_alu_unit.

Test Plan:
- add: srcA=32'h7FFF_FFFF, srcB=1, code 0, outReady=1 -> outValid one cycle after accept, aluResult=32'h8000_0000, zero=0; then sub 5-5 -> aluResult=0, zero=1.
- slt vs sltu: srcA=32'hFFFF_FFFF, srcB=1 -> slt result 1, sltu result 0.
- sra: srcA=32'h8000_0010, srcB=4 -> outValid exactly 4 cycles after accept, aluResult=32'hF800_0001. srl with the same inputs -> 32'h0800_0001. sll srcA=1, srcB=32'hFFFF_FFE0 (shamt 0) -> result 1 after 1 cycle.
- Backpressure: hold outReady=0 for 5 cycles after outValid -> result stable, inReady=0, a new inValid is ignored; release -> IDLE, then the pending request is accepted.
- Illegal code 4'hC -> aluResult=0, zero=1, illegalOp=1, latency 1.
- Reset asserted during the 3rd cycle of a 20-bit sll -> next cycle IDLE, outValid=0, aluResult=0; the next request completes normally.
